// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: data-memory responder for the pipelined CPU.
// A valid/ready request/response handshake with LATENCY wait states,
// a 32-bit word store with byte-strobe writes, and single outstanding access.
// Optional macro DMEM_ERR_CHECK_EN enables misalignment/range fault checks;
// without it low address bits are ignored and addresses wrap modulo depth.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic [31:0]             mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_access;
    logic                    w_acc_we;
    logic [31:0]             w_acc_addr;
    logic [31:0]             w_acc_wdata;
    logic [3:0]              w_acc_wstrb;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_err;

    assign w_accept = (r_state == IDLE) && req_valid;

    // With zero wait states the access happens on the accept edge straight from
    // the request bus; otherwise it uses the operands latched at accept.
    assign w_access = (w_accept && (LATENCY == 0)) ||
                      ((r_state == WAIT) && (r_cnt <= 4'd1));

    assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;
    assign w_idx       = w_acc_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign w_err = (w_acc_addr[1:0] != 2'b00) ||
                   (w_acc_addr[31:ADDR_WIDTH+2] != '0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{w_acc_addr[31:ADDR_WIDTH+2], w_acc_addr[1:0]};
    assign w_err         = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Next-state and request-ready decode.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY);
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response registers: loaded on the access edge, held until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_acc_we || w_err) ? '0 : mem[w_idx];
        end else if ((r_state == RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Byte-lane store; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_access && w_acc_we && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_acc_wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Bench for dmem_responder: directed literal cases followed by randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_dmem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    bit rr_rand  = 1'b0;
    bit rr_val   = 1'b1;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Response back-pressure source: fixed or random, updated just after each edge.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t: DUT did not respond within the cycle bound", name, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mmem [DEPTH];
    bit          m_busy  = 1'b0;
    bit          m_resp  = 1'b0;
    bit          m_rst   = 1'b0;
    int unsigned m_age   = 0;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;
    logic        t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;

    task automatic model_access();
        bit          f;
        logic [31:0] mask;
        f = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        f = (t_addr % 4 != 0) || ((t_addr >> (AW + 2)) != 0);
`endif
        m_err   = f;
        m_rdata = '0;
        if (!f) begin
            if (t_we) begin
                mask = '0;
                for (int i = 0; i < 4; i++) begin
                    if (t_wstrb[i]) mask = mask | (32'hFF << (8 * i));
                end
                mmem[t_addr[AW+1:2]] = (mmem[t_addr[AW+1:2]] & ~mask) | (t_wdata & mask);
            end else begin
                m_rdata = mmem[t_addr[AW+1:2]];
            end
        end
        m_resp = 1'b1;
    endtask

    // A request accepted at edge N is served on edge N+LAT; one at a time.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_resp = 1'b0; m_rdata = '0; m_err = 1'b0; m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (m_resp) begin
                if (rsp_ready) begin
                    m_resp = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_busy) begin
                m_age++;
                if (m_age == LAT) model_access();
            end else if (req_valid) begin
                m_busy = 1'b1; m_age = 0;
                t_we = req_we; t_addr = req_addr; t_wdata = req_wdata; t_wstrb = req_wstrb;
                if (LAT == 0) model_access();
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
            if (m_resp || m_rst) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bit rdy;
        rdy = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        for (int g = 0; g < 100 && !rdy; g++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
        end
        if (!rdy) tmo("accept");
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
        bit seen;
        seen = 1'b0; lat = 0; d = '0; e = 1'b0;
        for (int g = 0; g < 100 && !seen; g++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1; d = rsp_rdata; e = rsp_err;
            end else begin
                lat++;
            end
        end
        if (!seen) tmo("response");
    endtask

    task automatic finish_rsp();
        bit done;
        done = 1'b0;
        for (int g = 0; g < 400 && !done; g++) begin
            @(posedge clk);
            done = rsp_ready;
        end
        if (!done) tmo("handshake");
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] d;
        logic        e;
        int          lat;
        issue(we, addr, wdata, strb);
        wait_rsp(d, e, lat);
        finish_rsp();
    endtask

    task automatic check_txn(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          lat;
        issue(we, addr, wdata, strb);
        wait_rsp(d, e, lat);
        chk({name, "_rdata"}, d, exp_d);
        chk({name, "_err"}, {31'b0, e}, {31'b0, exp_e});
        chk({name, "_latency"}, 32'(lat), 32'd2);
        finish_rsp();
    endtask

    initial begin
        logic [31:0] d, a;
        logic        e;
        int          lat, low, first, n;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        #1 reset = 1'b0;

        // Fill every word so later loads have known contents.
        for (int unsigned i = 0; i < DEPTH; i++) txn(1'b1, i << 2, $urandom, 4'hF);

        // Load latency and ready-low window.
        txn(1'b1, 32'h0, 32'h0000_0004, 4'hF);
        issue(1'b0, 32'h0, '0, '0);
        low = 0; first = -1; d = '0; e = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid && first < 0) begin
                first = k; d = rsp_rdata; e = rsp_err;
            end
            if (req_ready) break;
            low++;
        end
        chk("load0_rdata", d, 32'h0000_0004);
        chk("load0_err", {31'b0, e}, 32'd0);
        chk("load0_latency", 32'(first), 32'd2);
        chk("load0_ready_low_cycles", 32'(low), 32'd3);
        @(posedge clk); #1;

        txn(1'b1, 32'h8, 32'h0000_0003, 4'hF);
        check_txn("load8", 1'b0, 32'h8, '0, '0, 32'h0000_0003, 1'b0);
        txn(1'b1, 32'h4, 32'hAABB_CCDD, 4'hF);
        check_txn("strb0101_store", 1'b1, 32'h4, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        check_txn("strb0101_load", 1'b0, 32'h4, '0, '0, 32'hAA22_CC44, 1'b0);
        check_txn("strb0_store", 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        check_txn("strb0_load", 1'b0, 32'h4, '0, '0, 32'hAA22_CC44, 1'b0);
`ifdef DMEM_ERR_CHECK_EN
        check_txn("misaligned_store", 1'b1, 32'h6, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
        check_txn("after_misaligned", 1'b0, 32'h4, '0, '0, 32'hAA22_CC44, 1'b0);
        check_txn("out_of_range_load", 1'b0, 32'h1000, '0, '0, 32'h0, 1'b1);
`else
        check_txn("unaligned_load", 1'b0, 32'h6, '0, '0, 32'hAA22_CC44, 1'b0);
        check_txn("wrap_load", 1'b0, 32'h1000, '0, '0, 32'h0000_0004, 1'b0);
`endif

        // Back-pressure: response held, second request ignored.
        rr_val = 1'b0;
        issue(1'b0, 32'h8, '0, '0);
        wait_rsp(d, e, lat);
        chk("bp_rdata", d, 32'h0000_0003);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wdata = '0; req_wstrb = '0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata_held", rsp_rdata, 32'h0000_0003);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rr_val = 1'b1;
        finish_rsp();
        issue(1'b0, 32'h0, '0, '0);
        wait_rsp(d, e, lat);
        chk("bp_second_rdata", d, 32'h0000_0004);
        finish_rsp();

        // Reset while waiting: store abandoned.
        issue(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_wait_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check_txn("rst_wait_mem", 1'b0, 32'h0, '0, '0, 32'h0000_0004, 1'b0);

        // Reset while responding: response dropped.
        rr_val = 1'b0;
        issue(1'b0, 32'h8, '0, '0);
        wait_rsp(d, e, lat);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; rr_val = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_resp_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Reset and request together: nothing accepted.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h55; req_wstrb = 4'hF;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_req_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_txn("rst_req_mem", 1'b0, 32'h0, '0, '0, 32'h0000_0004, 1'b0);

        // Randomized traffic with random back-pressure and gaps.
        rr_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            a = $urandom_range(0, DEPTH - 1) << 2;
            n = $urandom_range(0, 7);
            if (n == 0) a = a | $urandom_range(1, 3);
            else if (n == 1) a = a | ($urandom_range(1, 255) << (AW + 2));
            issue(1'($urandom), a, $urandom, 4'($urandom));
            wait_rsp(d, e, lat);
            chk("rand_latency", 32'(lat), 32'(LAT));
            finish_rsp();
            n = $urandom_range(0, 2);
            if (n != 0) begin
                repeat (n) @(posedge clk);
                #1;
            end
        end
        rr_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
